// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sipo_pkg
// Brief   : Shared state encoding and default frame width for sipo_rx_ctrl.
// Revision: 1.0
// ============================================================================
package sipo_pkg;

  localparam int c_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sipo_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sipo_rx_ctrl_if
// Brief   : Serial input, holding-register handshake and status of the receiver.
// Revision: 1.0
// ============================================================================
interface sipo_rx_ctrl_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
);

  logic             sdi;
  logic             sdi_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  modport master (
    input  sdi, sdi_en, dout_ready,
    output dout, dout_valid, busy, frame_err, overrun
  );

  modport slave (
    output sdi, sdi_en, dout_ready,
    input  dout, dout_valid, busy, frame_err, overrun
  );

endinterface
`default_nettype wire

// File: rtl/sipo_shift_en.sv
`default_nettype none
// ============================================================================
// Module  : sipo_shift_en
// Brief   : WIDTH-bit serial-in parallel-out register, enable and sync clear.
// Revision: 1.0
// ============================================================================
module sipo_shift_en
  import sipo_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             clr_i,
  input  wire logic             en_i,
  input  wire logic             sd_i,
  output logic      [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= {q_q[WIDTH-2:0], sd_i};
    end
  end

  assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/sipo_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sipo_rx_ctrl
// Brief   : Framed serial receiver (start 1, WIDTH bits MSB-first, stop 0).
// Revision: 1.0
// ============================================================================
module sipo_rx_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input wire logic      clk,
  input wire logic      reset,
  sipo_rx_ctrl_if.master bus
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [c_CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             shift_en;
  logic [WIDTH-1:0] sr_w;

  sipo_shift_en #(
    .WIDTH (WIDTH)
  ) u_sr (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (shift_en),
    .sd_i  (bus.sdi),
    .q_o   (sr_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q & ~bus.dout_ready;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    shift_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sdi_en && bus.sdi) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bus.sdi_en) begin
          shift_en = 1'b1;
          if (cnt_q == c_LAST) begin
            state_d = STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_CW'(1);
          end
        end
      end
      STOP: begin
        if (bus.sdi_en) begin
          state_d = IDLE;
          if (bus.sdi) begin
            frame_err_d = 1'b1;
          // A same-edge drain frees the holding register for the new word.
          end else if (!dout_valid_q || bus.dout_ready) begin
            dout_d       = sr_w;
            dout_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: doc/sipo_rx_ctrl.md
SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the payload bits per frame (legal 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset (one clock, sync active-high reset).
REQ-004 SHALL have port sdi  input  1  serial data line; idle level 0.
REQ-005 SHALL have port sdi_en  input  1  bit strobe; sdi is sampled only on edges where sdi_en=1.
REQ-006 SHALL have port dout  output  WIDTH  last accepted payload word.
REQ-007 SHALL have port dout_valid  output  1  dout holds an unconsumed word.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid=1.
REQ-009 SHALL have port busy  output  1  frame reception in progress (state != IDLE).
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and STOP; a frame is a start bit (1), then WIDTH payload bits MSB-first, then a stop bit (0).
REQ-013 SHALL, in IDLE, move to SHIFT with bit counter = 0 on an edge where sdi_en=1 and sdi=1; otherwise remain in IDLE.
REQ-014 SHALL, in SHIFT, on each edge with sdi_en=1, shift sdi into the LSB of the shift register ({sr[WIDTH-2:0], sdi}) and increment the counter.
REQ-015 SHALL move from SHIFT to STOP on the sdi_en edge that captures payload bit WIDTH-1; the counter width SHALL be clog2(WIDTH).
REQ-016 SHALL hold state, counter and shift register unchanged on any edge with sdi_en=0.
REQ-017 SHALL, in STOP on an sdi_en edge with sdi=0, treat the frame as good:
- load dout from the shift register and set dout_valid, if the holding register is empty or is drained on the same edge (dout_valid & dout_ready);
- otherwise pulse overrun for one cycle and keep the old dout.
REQ-018 SHALL, in STOP on an sdi_en edge with sdi=1, pulse frame_err for one cycle and discard the payload.
REQ-019 SHALL return to IDLE after either STOP outcome; a new start bit is accepted no earlier than the next sdi_en edge.
REQ-020 SHALL assert dout_valid on the clock edge that samples a good stop bit, so it is visible the following cycle (latency 1 cycle from stop bit).
REQ-021 SHALL clear dout_valid on an edge where dout_valid & dout_ready and no load occurs; on a simultaneous drain and load it SHALL keep dout_valid=1 with the new word.
REQ-022 SHALL keep dout stable while dout_valid=1 and no handshake completes.
REQ-023 SHALL not raise frame_err and overrun on the same cycle.

Reset
REQ-024 SHALL, on a clk edge with reset=1, force state IDLE, counter 0, shift register 0, dout 0, dout_valid 0, busy 0, frame_err 0 and overrun 0.
REQ-025 SHALL let reset take priority over every other event; reset mid-frame SHALL abandon the frame without pulsing frame_err or overrun.

Structure
REQ-026 SHALL place the state encoding typedef (IDLE/SHIFT/STOP) and the default WIDTH constant in the shared package sipo_pkg.
REQ-027 SHALL instantiate one sub-module, sipo_shift_en: a WIDTH-bit SIPO with shift enable and synchronous clear, driven by this controller.

Verification
REQ-028 SHALL cover a good frame with WIDTH=4, sdi_en=1 every cycle: bits 1,1,0,1,1,0 -> dout=4'b1011, dout_valid=1 one cycle after the stop edge, busy low again.
REQ-029 SHALL cover a bad stop: bits 1,0,1,0,1,1 -> frame_err pulses one cycle, dout_valid stays 0, FSM in IDLE.
REQ-030 SHALL cover overrun: two good frames 4'b1011 then 4'b0110 with dout_ready=0 -> overrun pulses once, dout stays 4'b1011.
REQ-031 SHALL cover simultaneous drain and load: dout_ready=1 on the second frame's stop edge -> dout=4'b0110, dout_valid remains 1, no overrun.
REQ-032 SHALL cover a gapped strobe: sdi_en=1 every third cycle with frame 1,0,0,1,1,0 -> dout=4'b0011, no state change on non-strobe cycles.
REQ-033 SHALL cover reset mid-frame: reset=1 for one cycle after two payload bits -> all outputs 0, no pulses, and the next full frame is received correctly.
